// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 digest serializer.
// Hex-ASCII output is enabled by defining SHA256_SER_HEX_ASCII_EN.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_TX,
    S_GAP,
    S_DONE
  } ser_state_t;

  localparam int DIGEST_W_DFLT = 256;
  localparam int DIGEST_BYTES  = 32;

  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h61;

endpackage

// File: rtl/sha256_digest_serializer_if.sv
// Digest capture and UART transmitter handshake bundle.
// slave = serializer, master = digest source / transmitter side.
interface sha256_digest_serializer_if
  import sha256_pkg::*;
#(
  parameter int DIGEST_W = DIGEST_W_DFLT
);

  logic [DIGEST_W-1:0] digest_in;
  logic                digest_dv_in;
  logic                tx_done_in;
  logic                tx_dv_out;
  logic [7:0]          tx_byte_out;
  logic                busy_out;
  logic                done_out;
  logic                overrun_out;

  modport master (
    output digest_in,
    output digest_dv_in,
    output tx_done_in,
    input  tx_dv_out,
    input  tx_byte_out,
    input  busy_out,
    input  done_out,
    input  overrun_out
  );

  modport slave (
    input  digest_in,
    input  digest_dv_in,
    input  tx_done_in,
    output tx_dv_out,
    output tx_byte_out,
    output busy_out,
    output done_out,
    output overrun_out
  );

endinterface

// File: rtl/hex_nibble_to_ascii.sv
// Maps a 4-bit nibble to its lowercase ASCII hex character.
// Used only when SHA256_SER_HEX_ASCII_EN is defined.
module hex_nibble_to_ascii
  import sha256_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = ASCII_DIGIT_BASE + {4'h0, nibble};
    if (nibble > 4'd9) begin
      ascii = ASCII_ALPHA_BASE + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/sha256_digest_serializer.sv
// Captures a digest and streams it MSB-first to a UART transmitter.
// SHA256_SER_HEX_ASCII_EN selects two ASCII hex chars per byte.
module sha256_digest_serializer
  import sha256_pkg::*;
#(
  parameter int DIGEST_W   = DIGEST_W_DFLT,
  parameter int GAP_CYCLES = 0
) (
  input logic                       clk,
  input logic                       rst_n,
  sha256_digest_serializer_if.slave bus
);

`ifdef SHA256_SER_HEX_ASCII_EN
  localparam int UNITS = 2 * (DIGEST_W / 8);
`else
  localparam int UNITS = DIGEST_W / 8;
`endif
  localparam logic [5:0]  LAST    = 6'(UNITS - 1);
  localparam logic [15:0] GAP_LD  = 16'(GAP_CYCLES - 1);
  localparam bit          HAS_GAP = (GAP_CYCLES > 0);

  ser_state_t          state_q;
  logic [DIGEST_W-1:0] shift_q;
  logic [DIGEST_W-1:0] l_shift;
  logic [5:0]          cnt_q;
  logic [5:0]          l_cnt;
  logic [15:0]         gap_q;
  logic [7:0]          l_byte;
  logic                adv;

  logic                tx_dv_q;
  logic [7:0]          tx_byte_q;
  logic                busy_q;
  logic                done_q;
  logic                ovr_q;

`ifdef SHA256_SER_HEX_ASCII_EN
  logic [3:0] l_nib;

  // shift only once both characters of a byte are out
  assign adv   = cnt_q[0];
  assign l_nib = l_cnt[0] ? l_shift[DIGEST_W-5 -: 4]
                          : l_shift[DIGEST_W-1 -: 4];

  hex_nibble_to_ascii u_hex (
    .nibble (l_nib),
    .ascii  (l_byte)
  );
`else
  assign adv    = 1'b1;
  assign l_byte = l_shift[DIGEST_W-1 -: 8];
`endif

  // shift/count view of the unit about to be launched
  always_comb begin
    l_shift = shift_q;
    l_cnt   = cnt_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        l_shift = bus.digest_in;
        l_cnt   = '0;
      end
      (state_q == S_WAIT_TX): begin
        l_shift = adv ? (shift_q << 8) : shift_q;
        l_cnt   = cnt_q + 6'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      tx_dv_q <= 1'b0;
      done_q  <= 1'b0;

      if (bus.digest_dv_in && state_q != S_IDLE) begin
        ovr_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (bus.digest_dv_in) begin
            shift_q   <= l_shift;
            cnt_q     <= l_cnt;
            tx_dv_q   <= 1'b1;
            tx_byte_q <= l_byte;
            busy_q    <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          state_q <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (bus.tx_done_in) begin
            if (cnt_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              shift_q <= l_shift;
              cnt_q   <= l_cnt;
              if (HAS_GAP) begin
                gap_q   <= GAP_LD;
                state_q <= S_GAP;
              end else begin
                tx_dv_q   <= 1'b1;
                tx_byte_q <= l_byte;
                state_q   <= S_SEND;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= l_byte;
            state_q   <= S_SEND;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_dv_out   = tx_dv_q;
  assign bus.tx_byte_out = tx_byte_q;
  assign bus.busy_out    = busy_q;
  assign bus.done_out    = done_q;
  assign bus.overrun_out = ovr_q;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Directed scoreboard bench for sha256_digest_serializer.
// Instance dut0 has no gap; dut3 inserts 3 idle cycles per unit.
module tb_sha256_digest_serializer;
  import sha256_pkg::*;

  localparam int DW = 256;
`ifdef SHA256_SER_HEX_ASCII_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  localparam logic [DW-1:0] ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha256_digest_serializer_if #(.DIGEST_W(DW)) bus0 ();
  sha256_digest_serializer_if #(.DIGEST_W(DW)) bus3 ();

  sha256_digest_serializer #(.DIGEST_W(DW), .GAP_CYCLES(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  sha256_digest_serializer #(.DIGEST_W(DW), .GAP_CYCLES(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp3[$];

  int  dly0 = 0, last_launch0 = 0, last_done0 = 0;
  int  dones0 = 0, xfer0 = 0;
  bit  first0 = 1'b1, spur_send = 1'b0;
  int  dly3 = 0, last_done3 = 0, dones3 = 0;
  bit  first3 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  task automatic push_digest(input logic [DW-1:0] d, input bit to3);
    logic [7:0] b;
    for (int i = 0; i < DW / 8; i++) begin
      b = d[DW-1-8*i -: 8];
      if (HEX) begin
        if (to3) begin exp3.push_back(asc(b[7:4])); exp3.push_back(asc(b[3:0])); end
        else     begin exp0.push_back(asc(b[7:4])); exp0.push_back(asc(b[3:0])); end
      end else begin
        if (to3) exp3.push_back(b);
        else     exp0.push_back(b);
      end
    end
  endtask

  // one cycle: transmitter models plus output monitors for both DUTs
  task automatic tick();
    logic t0, t3;
    @(negedge clk);
    cyc++;
    t0 = 1'b0;
    t3 = 1'b0;
    if (!rst_n) begin dly0 = 0; dly3 = 0; end
    if (dly0 > 0) begin
      dly0--;
      if (dly0 == 0) begin t0 = 1'b1; last_done0 = cyc; end
    end
    if (bus0.tx_dv_out) begin
      xfer0++;
      if (exp0.size() == 0) chk("launch_with_empty_sb0", exp0.size(), 1);
      else chk("byte0", bus0.tx_byte_out, exp0.pop_front());
      if (!first0) chk("gap0_latency", cyc, last_done0 + 1);
      first0 = 1'b0;
      dly0 = 10;
      last_launch0 = cyc;
      if (spur_send) begin t0 = 1'b1; spur_send = 1'b0; end
    end
    if (bus0.done_out) begin
      dones0++;
      chk("done0_vs_launch", cyc, last_launch0 + 11);
      chk("done0_vs_txdone", cyc, last_done0 + 1);
      chk("sb0_empty_at_done", exp0.size(), 0);
    end
    if (dly3 > 0) begin
      dly3--;
      if (dly3 == 0) begin t3 = 1'b1; last_done3 = cyc; end
    end
    if (bus3.tx_dv_out) begin
      if (exp3.size() == 0) chk("launch_with_empty_sb3", exp3.size(), 1);
      else chk("byte3", bus3.tx_byte_out, exp3.pop_front());
      if (!first3) chk("gap3_latency", cyc, last_done3 + 4);
      first3 = 1'b0;
      dly3 = 3;
    end
    if (bus3.done_out) begin
      dones3++;
      chk("done3_vs_txdone", cyc, last_done3 + 1);
      chk("sb3_empty_at_done", exp3.size(), 0);
    end
    bus0.tx_done_in = t0;
    bus3.tx_done_in = t3;
  endtask

  task automatic start0(input logic [DW-1:0] d);
    push_digest(d, 1'b0);
    first0 = 1'b1;
    xfer0 = 0;
    bus0.digest_in = d;
    bus0.digest_dv_in = 1'b1;
    tick();
    bus0.digest_dv_in = 1'b0;
    chk("launch_latency_dv", bus0.tx_dv_out, 1'b1);
    chk("launch_latency_busy", bus0.busy_out, 1'b1);
  endtask

  task automatic pulse_dv0(input logic [DW-1:0] d);
    bus0.digest_in = d;
    bus0.digest_dv_in = 1'b1;
    tick();
    bus0.digest_dv_in = 1'b0;
  endtask

  task automatic wait_done0(input int budget);
    int d0;
    d0 = dones0;
    for (int i = 0; i < budget && dones0 == d0; i++) tick();
    chk("done0_seen", dones0, d0 + 1);
  endtask

  task automatic run_to_launch0(input int n, input int budget);
    for (int i = 0; i < budget && xfer0 < n; i++) tick();
    chk("launch_count_reached", xfer0, n);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_dv"}, bus0.tx_dv_out, 1'b0);
    chk({tag, "_tx_byte"}, bus0.tx_byte_out, 8'h00);
    chk({tag, "_busy"}, bus0.busy_out, 1'b0);
    chk({tag, "_done"}, bus0.done_out, 1'b0);
    chk({tag, "_overrun"}, bus0.overrun_out, 1'b0);
  endtask

  initial begin
    bus0.digest_in = '0;
    bus0.digest_dv_in = 1'b0;
    bus0.tx_done_in = 1'b0;
    bus3.digest_in = '0;
    bus3.digest_dv_in = 1'b0;
    bus3.tx_done_in = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // stray done while idle must not start anything
    bus0.tx_done_in = 1'b1;
    tick();
    tick();
    chk("idle_spur_busy", bus0.busy_out, 1'b0);
    chk("idle_spur_dv", bus0.tx_dv_out, 1'b0);

    // abc digest with a stray done in the first SEND cycle
    spur_send = 1'b1;
    start0(ABC);
    wait_done0(2000);
    chk("busy_at_done", bus0.busy_out, 1'b1);
    tick();
    chk("busy_after_done", bus0.busy_out, 1'b0);
    chk("no_overrun_clean", bus0.overrun_out, 1'b0);
    chk("units_abc", xfer0, HEX ? 64 : 32);

    // overrun mid-transfer, then a pulse in the DONE cycle
    start0(ABC);
    run_to_launch0(5, 200);
    pulse_dv0('1);
    chk("overrun_set", bus0.overrun_out, 1'b1);
    wait_done0(2000);
    chk("units_overrun", xfer0, HEX ? 64 : 32);
    pulse_dv0({DW/8{8'h55}});
    chk("done_cycle_dv_dropped", bus0.busy_out, 1'b0);
    repeat (3) tick();
    chk("still_idle", bus0.busy_out, 1'b0);
    chk("overrun_sticky", bus0.overrun_out, 1'b1);

    // reset while byte 10 is in flight
    start0(ABC);
    run_to_launch0(10, 300);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    exp0.delete();
    dly0 = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_vals("postreset");
    start0({{(DW-8){1'b0}}, 8'h01});
    wait_done0(2000);
    chk("units_one", xfer0, HEX ? 64 : 32);

    // gap instance
    push_digest(ABC, 1'b1);
    bus3.digest_in = ABC;
    bus3.digest_dv_in = 1'b1;
    tick();
    bus3.digest_dv_in = 1'b0;
    chk("gap_launch_dv", bus3.tx_dv_out, 1'b1);
    for (int i = 0; i < 1000 && dones3 == 0; i++) tick();
    chk("done3_seen", dones3, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_digest_serializer.md
# sha256_digest_serializer

Downstream stage of the SHA-256 core: captures one 256-bit digest and feeds it byte-by-byte to the UART transmitter, pacing each byte on the transmitter's done pulse. It sits between the core's digest output and the transmitter's `Tx_DV_in`/`Tx_Byte_in` pair, replacing ad-hoc byte selection with a proper handshake-driven FSM. It also flags digests that arrive while a transfer is still running.

## Interface
- `DIGEST_W`, 256: digest width in bits; must be a multiple of 8.
- `GAP_CYCLES`, 0: idle cycles inserted after each `tx_done_in` before the next byte is launched.
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `digest_in` in 256: digest, big-endian (H0 in bits 255:224).
- `digest_dv_in` in 1: one-cycle pulse; `digest_in` is valid in that cycle.
- `tx_done_in` in 1: one-cycle pulse from the transmitter when the current byte has finished on the line.
- `tx_dv_out` out 1: one-cycle launch pulse to the transmitter.
- `tx_byte_out` out 8: byte to transmit; held stable from launch until its `tx_done_in`.
- `busy_out` out 1: high from capture until `done_out`, inclusive.
- `done_out` out 1: one-cycle pulse after the last byte completes.
- `overrun_out` out 1: sticky; set when `digest_dv_in` arrives while `busy_out`=1; cleared only by reset.

## Operation
- **States:** IDLE, SEND, WAIT_TX, GAP, DONE.
- **IDLE:**
  - On `digest_dv_in`: capture `digest_in` into a shift register, clear the byte counter, go to SEND.
  - `tx_done_in` is ignored in this state.
- **SEND:**
  - Drive `tx_byte_out` = shift register [255:248].
  - Assert `tx_dv_out` for exactly one cycle, then go to WAIT_TX.
- **WAIT_TX:**
  - Stay until `tx_done_in`=1.
  - Last unit sent: go to DONE.
  - Otherwise: shift left by 8, increment the counter, then go to GAP if `GAP_CYCLES`>0, else SEND.
- **GAP:** count `GAP_CYCLES` cycles, then go to SEND.
- **DONE:** pulse `done_out`, go to IDLE.
- **Byte order:** MSB first; byte 0 is `digest_in[255:248]`; 32 units per digest in raw mode.
- **Counter:** 6 bits wide, so it covers 64 units in hex mode; it never wraps within a transfer.
- **Overrun:** a `digest_dv_in` in any non-IDLE state is dropped and sets `overrun_out`. The transfer in progress is unaffected.
- **Simultaneous events:**
  - `digest_dv_in` in the same cycle as DONE→IDLE is dropped and flagged as overrun.
  - `tx_done_in` in the SEND cycle itself is ignored; only WAIT_TX samples it.
- **Reset mid-transfer:** returns to IDLE immediately; the shift register and counter clear; no further `tx_dv_out` is issued.

## Timing
- **Reset values:** `tx_dv_out`=0, `tx_byte_out`=8'h00, `busy_out`=0, `done_out`=0, `overrun_out`=0; state IDLE.
- **Launch latency:** capture edge at cycle N → `tx_dv_out`=1 in cycle N+1; `busy_out`=1 from cycle N+1.
- **Byte-to-byte:** `tx_done_in` in cycle M → next `tx_dv_out` in cycle M+1+`GAP_CYCLES`.
- **Completion:** last `tx_done_in` in cycle M → `done_out`=1 in M+1; `busy_out` falls in M+2.
- **Output style:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **`SHA256_SER_HEX_ASCII_EN` defined:** each byte is sent as two lowercase ASCII hex characters, high nibble first.
  - Nibble 0–9 → 0x30–0x39; a–f → 0x61–0x66.
  - 64 units per digest.
  - The shift register advances on every second `tx_done_in`.
- **Undefined:** 32 raw bytes per digest.

## Structure
- **Package `sha256_pkg`:**
  - FSM state enum `ser_state_t`.
  - `DIGEST_W` default.
  - `DIGEST_BYTES`=32.
  - ASCII base constants 8'h30 and 8'h61.
- **Sub-module `hex_nibble_to_ascii`:**
  - Combinational 4→8 map.
  - Instantiated only under `SHA256_SER_HEX_ASCII_EN`.

## Test plan
- **Raw "abc" digest:** digest ba7816bf…f20015ad, transmitter model returns `tx_done_in` 10 cycles after each launch → exactly 32 `tx_dv_out` pulses, bytes 0xBA, 0x78, 0x16 … 0x15, 0xAD; one `done_out` 11 cycles after the last launch.
- **Hex mode, same digest:** → 64 characters; the first four are 0x62, 0x61, 0x37, 0x38 ("ba78"); the last is 0x64 ('d').
- **Overrun:** `digest_dv_in` pulsed at byte 5 with digest all 0xFF → `overrun_out`=1 and stays set; the output stream still equals the first digest.
- **Gap:** `GAP_CYCLES`=3, `tx_done_in` in cycle M → next `tx_dv_out` exactly in cycle M+4.
- **Reset mid-transfer:** `rst_n` asserted during byte 10 → all outputs return to reset values immediately. After release, a new digest 0x00…01 sends 31 bytes of 0x00 followed by 0x01.
- **Spurious done:** `tx_done_in` pulses in IDLE and during SEND → ignored; no byte is skipped and the counter does not advance.
